mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory access stage that sits directly downstream of the 16-bit bus select mux. It captures the selected bus value into the address register (MAR) or data register (MDR) and runs read and write cycles against an asynchronous SRAM with a programmable wait-state count. MDR drives back toward the bus mux as its memory-data input. Accesses are sequenced by a small FSM with a start/done handshake to the control unit.

## Interface

**Parameters**
- WAIT_CYCLES, default 2: SRAM access wait states, legal range 1..15. A value of 0 is an elaboration error.

**Ports**
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- bus_in  in  16  bus value from the bus select mux output.
- ld_mar  in  1  load MAR from bus_in.
- ld_mdr  in  1  load MDR from bus_in.
- mem_rd_req  in  1  start a read of address MAR into MDR.
- mem_wr_req  in  1  start a write of MDR to address MAR.
- busy  out  1  an access is in progress.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  one-cycle pulse flagging an illegal request (see Operation).
- mar_out  out  16  current MAR.
- mdr_out  out  16  current MDR; feeds the bus mux.
- sram_addr  out  16  equals MAR.
- sram_wdata  out  16  equals MDR.
- sram_rdata  in  16  SRAM read data.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

## Operation

**States:** IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit down-counter `cnt` times the wait states.

**IDLE**
- ld_mar and ld_mdr load their registers at the clock edge.
- mem_rd_req moves to RD and sets cnt = WAIT_CYCLES-1.
- mem_wr_req (with no read request) moves to WR_SETUP.
- mem_rd_req and mem_wr_req high together: the read wins and err pulses.
- ld_mar with a request in the same cycle is legal. MAR holds the new value from the next cycle, so the access uses the new address.
- ld_mdr with mem_wr_req in the same cycle: the write uses the new MDR.

**RD**
- sram_ce_n=0, sram_oe_n=0.
- cnt decrements each cycle.
- At the edge where cnt==0: MDR <= sram_rdata and the FSM moves to DONE.

**Write sequence**
- WR_SETUP: 1 cycle, ce_n=0, we_n=1. Loads cnt = WAIT_CYCLES-1.
- WR_PULSE: ce_n=0, we_n=0, decrements cnt. At cnt==0 moves to WR_HOLD.
- WR_HOLD: 1 cycle, ce_n=0, we_n=1. Then moves to DONE.

**DONE**
- done=1 and busy=0 for one cycle, then unconditional return to IDLE.

**Outputs and illegal requests**
- busy=1 in RD, WR_SETUP, WR_PULSE and WR_HOLD; 0 elsewhere.
- sram_oe_n is 0 only in RD. sram_we_n is 0 only in WR_PULSE.
- In any state other than IDLE, every ld_mar, ld_mdr, mem_rd_req or mem_wr_req assertion is ignored and err pulses the following cycle. MAR and MDR are locked during an access.
- err is registered: it is high the cycle after the offending input.

## Timing

**Reset (Reset_n low)** takes effect immediately, without waiting for Clk:
- state=IDLE, MAR=0x0000, MDR=0x0000, cnt=0.
- sram_ce_n=sram_oe_n=sram_we_n=1.
- busy=0, done=0, err=0.
- Reset asserted mid-access deasserts all strobes at once. The interrupted access has no effect on MAR or MDR beyond reset.

**Read latency:** request sampled at edge 0.
- RD occupies cycles 1..WAIT_CYCLES.
- MDR is updated at the end of cycle WAIT_CYCLES.
- done and the new mdr_out are visible in cycle WAIT_CYCLES+1.
- Total occupancy is WAIT_CYCLES+1 cycles.

**Write latency:** request sampled at edge 0.
- sram_ce_n is low for WAIT_CYCLES+2 cycles.
- sram_we_n is low for exactly WAIT_CYCLES cycles, strictly inside the ce_n window.
- done is high in cycle WAIT_CYCLES+3.

**General rules**
- sram_addr and sram_wdata are stable for the whole ce_n-low window, because the registers are locked.
- Minimum spacing between the starts of two accesses is one cycle after done. A request during DONE is rejected with err.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan

- **Reset:** Reset_n low during WR_PULSE -> we_n/ce_n return to 1 with no clock edge; MAR=MDR=0, busy=0 while reset is held.
- **Read, WAIT_CYCLES=2:** load MAR=0x3000, read with sram_rdata=0xBEEF -> oe_n low in cycles 1-2, mdr_out=0xBEEF and done=1 in cycle 3, busy=0 in cycle 3.
- **Write, WAIT_CYCLES=3:** MAR=0x0042, MDR=0x1234, write -> ce_n low cycles 1-5, we_n low cycles 2-4, sram_addr=0x0042 and sram_wdata=0x1234 stable throughout, done in cycle 6.
- **Conflicting requests:** mem_rd_req and mem_wr_req together in IDLE -> read performed, we_n never low, err=1 the next cycle.
- **Locked registers:** ld_mar with bus_in=0xFFFF during RD -> err pulses, MAR stays 0x3000, the read completes normally.
- **Back-to-back requests:** mem_rd_req in the DONE cycle -> err pulse, no access started. The same request one cycle later (IDLE) -> accepted, busy=1 the next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access stage: MAR/MDR capture from the bus mux and wait-stated
// read/write cycles against an asynchronous SRAM, with a start/done handshake.
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mar_out,
  output logic [15:0] mdr_out,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_access_unit: WAIT_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        err_q;
  logic        err_nxt;
  logic        mdr_capture;
  logic        is_idle;

  assign is_idle = (state == IDLE);

  // Any handshake input outside IDLE is illegal; in IDLE only a read+write collision is.
  assign err_nxt = is_idle ? (mem_rd_req & mem_wr_req)
                           : (ld_mar | ld_mdr | mem_rd_req | mem_wr_req);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mdr_capture = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        if (mem_rd_req) begin
          state_nxt = RD;
          cnt_nxt   = CNT_INIT;
        end else if (mem_wr_req) begin
          state_nxt = WR_SETUP;
        end
      end
      RD: begin
        busy      = 1'b1;
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (cnt == 4'd0) begin
          mdr_capture = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_SETUP: begin
        busy      = 1'b1;
        sram_ce_n = 1'b0;
        cnt_nxt   = CNT_INIT;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        busy      = 1'b1;
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt = WR_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_HOLD: begin
        busy      = 1'b1;
        sram_ce_n = 1'b0;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt   <= '0;
      mar   <= '0;
      mdr   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (is_idle && ld_mar) begin
        mar <= bus_in;
      end
      if (mdr_capture) begin
        mdr <= sram_rdata;
      end else if (is_idle && ld_mdr) begin
        mdr <= bus_in;
      end
    end
  end

  assign err        = err_q;
  assign mar_out    = mar;
  assign sram_addr  = mar;
  assign mdr_out    = mdr;
  assign sram_wdata = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance at WAIT_CYCLES=2 (lane 0)
// and one at WAIT_CYCLES=3 (lane 1), each with its own inputs and expectations.
module tb_mem_access_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n;
  logic [15:0] rdata;
  logic [15:0] bus_i   [2];
  logic        ld_mar_i[2];
  logic        ld_mdr_i[2];
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic        ce_o    [2];
  logic        oe_o    [2];
  logic        we_o    [2];
  logic [15:0] mar_o   [2];
  logic [15:0] mdr_o   [2];
  logic [15:0] addr_o  [2];
  logic [15:0] wdata_o [2];

  mem_access_unit #(.WAIT_CYCLES(2)) u_dut_w2 (
    .Clk(Clk), .Reset_n(Reset_n), .bus_in(bus_i[0]),
    .ld_mar(ld_mar_i[0]), .ld_mdr(ld_mdr_i[0]),
    .mem_rd_req(rd_i[0]), .mem_wr_req(wr_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
    .mar_out(mar_o[0]), .mdr_out(mdr_o[0]),
    .sram_addr(addr_o[0]), .sram_wdata(wdata_o[0]), .sram_rdata(rdata),
    .sram_ce_n(ce_o[0]), .sram_oe_n(oe_o[0]), .sram_we_n(we_o[0])
  );

  mem_access_unit #(.WAIT_CYCLES(3)) u_dut_w3 (
    .Clk(Clk), .Reset_n(Reset_n), .bus_in(bus_i[1]),
    .ld_mar(ld_mar_i[1]), .ld_mdr(ld_mdr_i[1]),
    .mem_rd_req(rd_i[1]), .mem_wr_req(wr_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
    .mar_out(mar_o[1]), .mdr_out(mdr_o[1]),
    .sram_addr(addr_o[1]), .sram_wdata(wdata_o[1]), .sram_rdata(rdata),
    .sram_ce_n(ce_o[1]), .sram_oe_n(oe_o[1]), .sram_we_n(we_o[1])
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] wdata;
    int unsigned ce;
    int unsigned oe;
    int unsigned we;
  } done_ev_t;

  done_ev_t    done_q[2][$];
  int unsigned err_q [2][$];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  int unsigned ce_cnt[2];
  int unsigned oe_cnt[2];
  int unsigned we_cnt[2];
  logic [15:0] lat_addr[2];
  logic [15:0] lat_wd[2];
  logic        unstable[2];
  logic        bad_we[2];
  logic        finish_req = 1'b0;
  logic        chk_done   = 1'b0;

  logic [15:0] m_mar[2];
  logic [15:0] m_mdr[2];

  task automatic chk(input int l, input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL lane%0d %s: got %0h required %0h (cycle %0d)", l, nm, got, exp, cyc);
    end
  endtask

  task automatic clear_trk(input int l);
    ce_cnt[l]   = 0;
    oe_cnt[l]   = 0;
    we_cnt[l]   = 0;
    unstable[l] = 1'b0;
    bad_we[l]   = 1'b0;
  endtask

  // Monitor: the only process that steps the tests/fails counters
  always @(negedge Clk or negedge Reset_n) begin
    done_ev_t    e;
    int unsigned ec;
    if (!Reset_n) begin
      #1;
      for (int l = 0; l < 2; l++) begin
        chk(l, "reset_state",
            64'({busy_o[l], done_o[l], err_o[l], ce_o[l], oe_o[l], we_o[l], mar_o[l], mdr_o[l]}),
            64'({3'b000, 3'b111, 32'h0}));
        clear_trk(l);
      end
    end else begin
      cyc++;
      for (int l = 0; l < 2; l++) begin
        if (!ce_o[l]) begin
          if (ce_cnt[l] == 0) begin
            lat_addr[l] = addr_o[l];
            lat_wd[l]   = wdata_o[l];
          end else if (addr_o[l] !== lat_addr[l] || wdata_o[l] !== lat_wd[l]) begin
            unstable[l] = 1'b1;
          end
          ce_cnt[l]++;
        end
        if (!oe_o[l]) oe_cnt[l]++;
        if (!we_o[l]) begin
          we_cnt[l]++;
          if (ce_o[l]) bad_we[l] = 1'b1;
        end
        if (done_o[l]) begin
          if (done_q[l].size() == 0) begin
            chk(l, "unexpected_done", 64'(done_o[l]), 64'd0);
          end else begin
            e = done_q[l].pop_front();
            chk(l, "done_cycle",  64'(cyc),        64'(e.cyc));
            chk(l, "mdr_out",     64'(mdr_o[l]),   64'(e.mdr));
            chk(l, "mar_out",     64'(mar_o[l]),   64'(e.mar));
            chk(l, "sram_addr",   64'(lat_addr[l]), 64'(e.mar));
            chk(l, "sram_wdata",  64'(lat_wd[l]),  64'(e.wdata));
            chk(l, "ce_low_cyc",  64'(ce_cnt[l]),  64'(e.ce));
            chk(l, "oe_low_cyc",  64'(oe_cnt[l]),  64'(e.oe));
            chk(l, "we_low_cyc",  64'(we_cnt[l]),  64'(e.we));
            chk(l, "addr_data_unstable", 64'(unstable[l]), 64'd0);
            chk(l, "we_outside_ce",      64'(bad_we[l]),   64'd0);
            chk(l, "busy_in_done",       64'(busy_o[l]),   64'd0);
          end
          clear_trk(l);
        end
        if (err_o[l]) begin
          if (err_q[l].size() == 0) begin
            chk(l, "unexpected_err", 64'(err_o[l]), 64'd0);
          end else begin
            ec = err_q[l].pop_front();
            chk(l, "err_cycle", 64'(cyc), 64'(ec));
          end
        end
      end
      if (finish_req && !chk_done) begin
        for (int l = 0; l < 2; l++) begin
          chk(l, "pending_done", 64'(done_q[l].size()), 64'd0);
          chk(l, "pending_err",  64'(err_q[l].size()),  64'd0);
          chk(l, "trailing_ce",  64'(ce_cnt[l]),        64'd0);
        end
        chk_done = 1'b1;
      end
    end
  end

  task automatic exp_done(input int l, input int unsigned c, input logic [15:0] mar,
                          input logic [15:0] mdr, input logic [15:0] wd,
                          input int unsigned ce, input int unsigned oe, input int unsigned we);
    done_ev_t e;
    e.cyc = c; e.mar = mar; e.mdr = mdr; e.wdata = wd;
    e.ce = ce; e.oe = oe; e.we = we;
    done_q[l].push_back(e);
  endtask

  // Entered just after a rising edge; holds the inputs for exactly one cycle.
  task automatic req(input int l, input logic lm, input logic ld, input logic rd,
                     input logic wr, input logic [15:0] b, output int unsigned n);
    n = cyc + 1;
    ld_mar_i[l] = lm;
    ld_mdr_i[l] = ld;
    rd_i[l]     = rd;
    wr_i[l]     = wr;
    bus_i[l]    = b;
    @(posedge Clk);
    #1;
    ld_mar_i[l] = 1'b0;
    ld_mdr_i[l] = 1'b0;
    rd_i[l]     = 1'b0;
    wr_i[l]     = 1'b0;
    bus_i[l]    = '0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned n2;
    Reset_n = 1'b0;
    rdata   = '0;
    for (int l = 0; l < 2; l++) begin
      bus_i[l] = '0; ld_mar_i[l] = 1'b0; ld_mdr_i[l] = 1'b0;
      rd_i[l] = 1'b0; wr_i[l] = 1'b0;
      m_mar[l] = '0; m_mdr[l] = '0;
      clear_trk(l);
    end
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(1);

    // Lane 0 (2 wait states): plain read
    req(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, n);
    m_mar[0] = 16'h3000;
    rdata = 16'hBEEF;
    req(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, n);
    exp_done(0, n + 3, m_mar[0], 16'hBEEF, m_mdr[0], 2, 2, 0);
    m_mdr[0] = 16'hBEEF;
    idle(3);

    // Locked MAR during RD, then a request in DONE, then one in IDLE
    rdata = 16'h1111;
    req(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, n);
    exp_done(0, n + 3, m_mar[0], 16'h1111, m_mdr[0], 2, 2, 0);
    m_mdr[0] = 16'h1111;
    req(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, n2);
    err_q[0].push_back(n2 + 1);
    idle(1);
    rdata = 16'h5A5A;
    req(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, n2);
    err_q[0].push_back(n2 + 1);
    req(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, n);
    exp_done(0, n + 3, m_mar[0], 16'h5A5A, m_mdr[0], 2, 2, 0);
    m_mdr[0] = 16'h5A5A;
    idle(4);

    // Read and write requested together: read wins, err next cycle
    rdata = 16'h0F0F;
    req(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, n);
    err_q[0].push_back(n + 1);
    exp_done(0, n + 3, m_mar[0], 16'h0F0F, m_mdr[0], 2, 2, 0);
    m_mdr[0] = 16'h0F0F;
    idle(4);

    // ld_mar with the read request: access uses the new address
    rdata = 16'h7777;
    req(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00A5, n);
    m_mar[0] = 16'h00A5;
    exp_done(0, n + 3, m_mar[0], 16'h7777, m_mdr[0], 2, 2, 0);
    m_mdr[0] = 16'h7777;
    idle(4);

    // ld_mdr with the write request at 2 wait states
    req(0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4321, n);
    m_mdr[0] = 16'h4321;
    exp_done(0, n + 5, m_mar[0], m_mdr[0], m_mdr[0], 4, 0, 2);
    idle(6);

    // Lane 1 (3 wait states): write 0x1234 to 0x0042
    req(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, n);
    m_mar[1] = 16'h0042;
    req(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, n);
    m_mdr[1] = 16'h1234;
    req(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, n);
    exp_done(1, n + 6, m_mar[1], m_mdr[1], m_mdr[1], 5, 0, 3);
    idle(6);

    req(1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, n);
    m_mdr[1] = 16'hCAFE;
    exp_done(1, n + 6, m_mar[1], m_mdr[1], m_mdr[1], 5, 0, 3);
    idle(6);

    rdata = 16'h9ABC;
    req(1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, n);
    exp_done(1, n + 4, m_mar[1], 16'h9ABC, m_mdr[1], 3, 3, 0);
    m_mdr[1] = 16'h9ABC;
    idle(5);

    // Reset in the middle of WR_PULSE; the aborted write never completes
    req(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, n);
    idle(2);
    #1;
    Reset_n = 1'b0;
    idle(2);
    Reset_n = 1'b1;
    for (int l = 0; l < 2; l++) begin
      m_mar[l] = '0;
      m_mdr[l] = '0;
    end
    idle(1);

    rdata = 16'h0BAD;
    req(1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, n);
    exp_done(1, n + 4, m_mar[1], 16'h0BAD, m_mdr[1], 3, 3, 0);
    idle(5);

    finish_req = 1'b1;
    for (int i = 0; i < 20 && !chk_done; i++) @(posedge Clk);
    if (!chk_done) begin
      $display("FAIL end_check: got no final check required final check within 20 cycles");
      $fatal(1);
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
